async_up_counter: RTL and testbench
===================================

ASYNC_UP_COUNTER -- requirements
Module: async_up_counter

Interface
REQ-001 Parameter: WIDTH, default 4, counter bit width (legal range 1..32).
REQ-002 Port: clk  input  1  single clock; counter advances on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset; rst=0 clears the counter, rst=1 lets it run.
REQ-004 Port: count  output  WIDTH  current counter value, unsigned, bit 0 = LSB.
REQ-005 The design SHALL have one clock and an asynchronous active-low reset, and no other ports.

Function
REQ-006 The counter SHALL be a ripple (asynchronous) counter built from WIDTH toggle stages, one flip-flop per count bit.
REQ-007 Stage 0 SHALL toggle on every rising edge of clk while rst=1.
REQ-008 Stage i (i>=1) SHALL toggle on the falling edge of stage i-1's output, i.e. when bit i-1 goes 1->0, so the value increments.
REQ-009 Each stage SHALL be a separate flop instance generated per bit; stages SHALL NOT share a common clock.
REQ-010 Net effect: count SHALL increase by exactly 1 (modulo 2^WIDTH) per rising clk edge while rst=1.
REQ-011 Wrap-around: from 2^WIDTH-1 (4'hF for WIDTH=4), the next rising clk edge SHALL give 0; no terminal-count flag, no saturation.
REQ-012 count SHALL be driven directly from the stage flop outputs, with no output register or decode logic.
REQ-013 Ripple settling: in zero-delay simulation, count SHALL settle within the same timestep as the clk edge.
REQ-014 In hardware, intermediate values during ripple are permitted; count is valid no later than WIDTH flop clock-to-Q delays after the edge.
REQ-015 Falling clk edges SHALL NOT change count.
REQ-016 No enable, load, or down-count function SHALL exist.

Reset
REQ-017 While rst=0, all stages SHALL be held at 0, so count=0, regardless of clk.
REQ-018 Reset assertion SHALL clear count immediately, with no clock edge required, including mid-ripple.
REQ-019 Reset clears of upper stages SHALL NOT produce any spurious toggle of a following stage.
REQ-020 Reset release SHALL be glitch-free: after rst rises, count stays 0 until the first rising clk edge, which makes count=1.
REQ-021 If rst rises coincident with a clk rising edge, that edge MAY or MAY NOT be counted.
REQ-022 Benches SHALL release rst away from rising clk edges.
REQ-023 There is no power-on value other than via reset; count is undefined until rst has been low at least once.

Verification
REQ-024 Reset hold: 10 ns clk period, rst=0 for 100 ns -> count=0 throughout, while clk toggles.
REQ-025 Count-up: release rst at t=100 ns (between edges) -> count reads 1,2,3,... on successive rising edges; no change on falling edges.
REQ-026 Wrap: run 16 rising edges from 0 with WIDTH=4 -> count goes 15 -> 0, then 1; the pattern repeats every 160 ns over a 2000 ns run.
REQ-027 Async reset mid-count: drive rst=0 between edges when count=4'hB -> count=0 immediately, with no clk edge; holds 0 until release.
REQ-028 Reset with ripple: assert rst just after the edge 4'h7->4'h8 -> count=0, with no stray nonzero value afterwards.
REQ-029 Parameter: WIDTH=8, 300 rising edges from reset -> count=300 mod 256 = 44 (8'h2C).

Source files
------------

// File: rtl/async_up_counter.sv
// Ripple (asynchronous) up counter.
// Each count bit is its own toggle flop: stage 0 runs off clk, every later
// stage is clocked by the falling edge of the stage below it, so a 1->0
// carry out of bit i-1 toggles bit i. All stages share an asynchronous
// active-low clear. count comes straight from the stage flop outputs.
module async_up_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count
);

  // Stage outputs, bit gi is driven by stage gi only.
  logic [WIDTH-1:0] w_stage_q;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
      logic r_q;

      if (gi == 0) begin : g_first
        // Stage 0 toggles on every rising clk edge while out of reset.
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            r_q <= 1'b0;
          end else begin
            r_q <= ~r_q;
          end
        end
      end else begin : g_ripple
        // Stage gi toggles when the stage below falls 1->0 (a carry).
        // A clear of the lower stage also produces such a falling edge,
        // but rst is low at that moment so the clear branch wins and no
        // stray toggle can occur.
        always_ff @(negedge w_stage_q[gi-1] or negedge rst) begin
          if (!rst) begin
            r_q <= 1'b0;
          end else begin
            r_q <= ~r_q;
          end
        end
      end

      assign w_stage_q[gi] = r_q;
    end
  endgenerate

  // Output taken directly from the stage flops; no decode or re-register.
  assign count = w_stage_q;

endmodule

// File: tb/tb_async_up_counter.sv
// Self-checking bench for async_up_counter (WIDTH=4 and WIDTH=8 instances).
module tb_async_up_counter;

  logic       clk;
  logic       rst4;
  logic       rst8;
  logic [3:0] count4;
  logic [7:0] count8;

  int n_checks = 0;
  int n_errors = 0;
  int model    = 0;   // reference value of the 4-bit counter

  typedef struct {
    int         n_edges;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[10];

  async_up_counter #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst   (rst4),
    .count (count4)
  );

  async_up_counter #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst8),
    .count (count8)
  );

  // 10 ns period, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "run exceeded time limit");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Rising edges needed to go from cur to target modulo 16 (at least one).
  function automatic int steps_to(input int target, input int cur);
    int d;
    d = ((target - cur) % 16 + 16) % 16;
    return (d == 0) ? 16 : d;
  endfunction

  task automatic advance(input int n);
    repeat (n) @(posedge clk);
    #1;
    model = (model + n) % 16;
  endtask

  initial begin
    int stray;

    vecs[0] = '{1, 4'd1};
    vecs[1] = '{1, 4'd2};
    vecs[2] = '{1, 4'd3};
    vecs[3] = '{11, 4'd14};
    vecs[4] = '{1, 4'd15};
    vecs[5] = '{1, 4'd0};
    vecs[6] = '{1, 4'd1};
    vecs[7] = '{16, 4'd1};
    vecs[8] = '{31, 4'd0};
    vecs[9] = '{5, 4'd5};

    rst4 = 1'b0;
    rst8 = 1'b0;

    // Reset hold for 100 ns while clk toggles.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold_w4", int'(count4), 0);
      check("reset_hold_w8", int'(count8), 0);
    end

    // Release at t=100 (a falling edge), away from rising edges.
    @(negedge clk);
    rst4 = 1'b1;
    #1;
    check("release_glitch_free", int'(count4), 0);
    model = 0;

    // Table-driven count-up and wrap, plus no change on falling edges.
    for (int v = 0; v < 10; v++) begin
      advance(vecs[v].n_edges);
      check($sformatf("vec%0d_count", v), int'(count4), int'(vecs[v].exp));
      check($sformatf("vec%0d_model", v), int'(count4), model);
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_negedge_hold", v), int'(count4), model);
    end

    // 2000 ns free run: 200 rising edges, wrapping every 16.
    for (int k = 0; k < 200; k++) begin
      advance(1);
      check("free_run", int'(count4), model);
    end

    // Asynchronous reset mid-count at 4'hB.
    advance(steps_to(11, model));
    check("reach_B", int'(count4), 11);
    @(negedge clk);
    #2;
    rst4 = 1'b0;
    #1;
    check("async_clear_immediate", int'(count4), 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("async_clear_hold", int'(count4), 0);
    end
    @(negedge clk);
    rst4 = 1'b1;
    #1;
    check("rerelease_zero", int'(count4), 0);
    model = 0;
    advance(1);
    check("first_edge_after_release", int'(count4), 1);

    // Reset just after the 7 -> 8 edge: no stray nonzero value afterwards.
    advance(steps_to(7, model));
    check("reach_7", int'(count4), 7);
    @(posedge clk);
    #1;
    check("reach_8", int'(count4), 8);
    rst4 = 1'b0;
    stray = 0;
    for (int k = 0; k < 25; k++) begin
      #1;
      if (count4 != 4'd0) stray++;
    end
    check("ripple_reset_stray", stray, 0);
    @(negedge clk);
    rst4 = 1'b1;
    model = 0;
    advance(1);
    check("after_ripple_reset", int'(count4), 1);

    // Randomized mix of reset pulses and counting runs.
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        #1;
        rst4 = 1'b0;
        #1;
        check("rand_reset", int'(count4), 0);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        @(negedge clk);
        rst4 = 1'b1;
        model = 0;
        #1;
        check("rand_release", int'(count4), 0);
      end else begin
        advance($urandom_range(1, 20));
        check("rand_count", int'(count4), model);
      end
    end

    // WIDTH=8: 300 rising edges from reset give 300 mod 256 = 44.
    check("w8_still_reset", int'(count8), 0);
    @(negedge clk);
    rst8 = 1'b1;
    repeat (255) @(posedge clk);
    #1;
    check("w8_255", int'(count8), 255);
    @(posedge clk);
    #1;
    check("w8_wrap", int'(count8), 0);
    repeat (44) @(posedge clk);
    #1;
    check("w8_300_edges", int'(count8), 44);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
